// File: rtl/interrupt_accept_sequencer.sv
// rtl/interrupt_accept_sequencer.sv - interrupt acceptance, stacking and vector fetch sequencer
// Optional bus-ack watchdog enabled by defining INT_SEQ_WDOG_EN.
module interrupt_accept_sequencer #(
  parameter int                ADDR_W      = 24,
  parameter logic [ADDR_W-1:0] VEC_BASE    = '0,
  parameter int                VEC_SHIFT   = 2,
  parameter int                WDOG_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              interrupt_request,
  input  logic [7:0]        vector_number,
  input  logic              NMI_req,
  input  logic [2:0]        int_level,
  input  logic              INTM0,
  input  logic              INTM1,
  input  logic              I_bit,
  input  logic              inst_boundary,
  input  logic [23:0]       pc_in,
  input  logic [7:0]        ccr_in,
  input  logic [7:0]        exr_in,
  input  logic [ADDR_W-1:0] sp_in,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              int_ack,
  output logic [7:0]        ack_vector,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [ADDR_W-1:0] sp_out,
  output logic [23:0]       pc_out,
  output logic              load,
  output logic              I_set,
  output logic [2:0]        exr_mask_out,
  output logic              seq_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_PUSH_EXR, S_PUSH_PCL, S_PUSH_PCH, S_FETCH_H, S_FETCH_L, S_UPDATE
  } state_t;

  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(2);
  localparam logic [7:0]        NMI_VECTOR = 8'd7;
  localparam logic [2:0]        NMI_LEVEL  = 3'd7;

  state_t            state_q, state_d;
  logic [7:0]        vec_q, vec_d;
  logic [2:0]        lvl_q, lvl_d;
  logic              mode2_q, mode2_d;
  logic [23:0]       pc_q, pc_d;
  logic [7:0]        ccr_q, ccr_d;
  logic [7:0]        exr_q, exr_d;
  logic [ADDR_W-1:0] sp_cur_q, sp_cur_d;
  logic [7:0]        vec_hi_q, vec_hi_d;
  logic              int_ack_q, int_ack_d;
  logic [7:0]        ack_vector_q, ack_vector_d;
  logic              busy_q, busy_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] sp_out_q, sp_out_d;
  logic [23:0]       pc_out_q, pc_out_d;
  logic              load_q, load_d;
  logic              i_set_q, i_set_d;
  logic [2:0]        exr_mask_q, exr_mask_d;

  logic              accept;
  logic              xfer_done;
  logic [ADDR_W-1:0] vec_addr;
  logic [ADDR_W-1:0] sp_next;

  // Acceptance window: NMI always wins; maskable requests need mode 0 with I clear, or mode 2.
  assign accept    = inst_boundary &
                     (NMI_req | (interrupt_request & ~INTM0 & (INTM1 | ~I_bit)));
  assign xfer_done = mem_req_q & mem_ack;
  assign vec_addr  = VEC_BASE + (ADDR_W'(vec_q) << VEC_SHIFT);
  assign sp_next   = sp_cur_q - WORD_BYTES;

`ifdef INT_SEQ_WDOG_EN
  logic [15:0] wdog_q, wdog_d;
  logic        seq_error_q, seq_error_d;
`endif

  // Next-state and next-output computation for the whole acceptance sequence.
  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    lvl_d        = lvl_q;
    mode2_d      = mode2_q;
    pc_d         = pc_q;
    ccr_d        = ccr_q;
    exr_d        = exr_q;
    sp_cur_d     = sp_cur_q;
    vec_hi_d     = vec_hi_q;
    int_ack_d    = 1'b0;
    ack_vector_d = ack_vector_q;
    busy_d       = busy_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    sp_out_d     = sp_out_q;
    pc_out_d     = pc_out_q;
    load_d       = 1'b0;
    i_set_d      = i_set_q;
    exr_mask_d   = exr_mask_q;
`ifdef INT_SEQ_WDOG_EN
    wdog_d       = wdog_q;
    seq_error_d  = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          vec_d        = NMI_req ? NMI_VECTOR : vector_number;
          lvl_d        = NMI_req ? NMI_LEVEL : int_level;
          mode2_d      = INTM1;
          pc_d         = pc_in;
          ccr_d        = ccr_in;
          exr_d        = exr_in;
          sp_cur_d     = sp_in;
          int_ack_d    = 1'b1;
          ack_vector_d = NMI_req ? NMI_VECTOR : vector_number;
          busy_d       = 1'b1;
          state_d      = S_ACK;
        end
      end

      S_ACK: begin
        // First push; EXR goes first in mode 2, otherwise PC low word.
        mem_req_d  = 1'b1;
        mem_we_d   = 1'b1;
        mem_addr_d = sp_next;
        sp_cur_d   = sp_next;
        if (mode2_q) begin
          mem_wdata_d = {8'h00, exr_q};
          state_d     = S_PUSH_EXR;
        end else begin
          mem_wdata_d = pc_q[15:0];
          state_d     = S_PUSH_PCL;
        end
      end

      S_PUSH_EXR: begin
        if (xfer_done) begin
          mem_addr_d  = sp_next;
          sp_cur_d    = sp_next;
          mem_wdata_d = pc_q[15:0];
          state_d     = S_PUSH_PCL;
        end
      end

      S_PUSH_PCL: begin
        if (xfer_done) begin
          mem_addr_d  = sp_next;
          sp_cur_d    = sp_next;
          mem_wdata_d = {ccr_q, pc_q[23:16]};
          state_d     = S_PUSH_PCH;
        end
      end

      S_PUSH_PCH: begin
        if (xfer_done) begin
          mem_we_d    = 1'b0;
          mem_addr_d  = vec_addr;
          mem_wdata_d = 16'h0000;
          state_d     = S_FETCH_H;
        end
      end

      S_FETCH_H: begin
        if (xfer_done) begin
          // Only the low byte of the high vector word forms PC[23:16].
          vec_hi_d   = mem_rdata[7:0];
          mem_addr_d = vec_addr + WORD_BYTES;
          state_d    = S_FETCH_L;
        end
      end

      S_FETCH_L: begin
        if (xfer_done) begin
          mem_req_d  = 1'b0;
          pc_out_d   = {vec_hi_q, mem_rdata};
          sp_out_d   = sp_cur_q;
          load_d     = 1'b1;
          i_set_d    = ~mode2_q;
          exr_mask_d = mode2_q ? lvl_q : exr_q[2:0];
          state_d    = S_UPDATE;
        end
      end

      S_UPDATE: begin
        busy_d  = 1'b0;
        i_set_d = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase

`ifdef INT_SEQ_WDOG_EN
    // Each transfer gets WDOG_CYCLES unacknowledged cycles before the sequence is abandoned.
    if (mem_req_q) begin
      if (mem_ack) begin
        wdog_d = '0;
      end else if (wdog_q == 16'(WDOG_CYCLES - 1)) begin
        wdog_d      = '0;
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        load_d      = 1'b0;
        i_set_d     = 1'b0;
        seq_error_d = 1'b1;
      end else begin
        wdog_d = wdog_q + 16'd1;
      end
    end else begin
      wdog_d = '0;
    end
`endif
  end

  // State and registered outputs; reset abandons any partially stacked frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      vec_q        <= '0;
      lvl_q        <= '0;
      mode2_q      <= 1'b0;
      pc_q         <= '0;
      ccr_q        <= '0;
      exr_q        <= '0;
      sp_cur_q     <= '0;
      vec_hi_q     <= '0;
      int_ack_q    <= 1'b0;
      ack_vector_q <= '0;
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      sp_out_q     <= '0;
      pc_out_q     <= '0;
      load_q       <= 1'b0;
      i_set_q      <= 1'b0;
      exr_mask_q   <= '0;
`ifdef INT_SEQ_WDOG_EN
      wdog_q       <= '0;
      seq_error_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      lvl_q        <= lvl_d;
      mode2_q      <= mode2_d;
      pc_q         <= pc_d;
      ccr_q        <= ccr_d;
      exr_q        <= exr_d;
      sp_cur_q     <= sp_cur_d;
      vec_hi_q     <= vec_hi_d;
      int_ack_q    <= int_ack_d;
      ack_vector_q <= ack_vector_d;
      busy_q       <= busy_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      sp_out_q     <= sp_out_d;
      pc_out_q     <= pc_out_d;
      load_q       <= load_d;
      i_set_q      <= i_set_d;
      exr_mask_q   <= exr_mask_d;
`ifdef INT_SEQ_WDOG_EN
      wdog_q       <= wdog_d;
      seq_error_q  <= seq_error_d;
`endif
    end
  end

  assign int_ack      = int_ack_q;
  assign ack_vector   = ack_vector_q;
  assign busy         = busy_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign sp_out       = sp_out_q;
  assign pc_out       = pc_out_q;
  assign load         = load_q;
  assign I_set        = i_set_q;
  assign exr_mask_out = exr_mask_q;

`ifdef INT_SEQ_WDOG_EN
  assign seq_error = seq_error_q;
`else
  // No watchdog: the error pulse can never occur (expression is constant 0).
  assign seq_error = (WDOG_CYCLES < 0);
`endif

endmodule
